// File: rtl/freq_measure_if.sv
// Measurement-sequencer bundle: edge/freeze in, published frequency word and flags out.
// Pure wiring; no latency or backpressure of its own.
interface freq_measure_if #(
    parameter int unsigned BIT_SIZE = 20
);
    logic                rise_edge;
    logic                freeze;
    logic [BIT_SIZE-1:0] frequency;
    logic                valid;
    logic                busy;
    logic                no_signal;
    logic                overrange;

    modport master (
        output rise_edge, freeze,
        input  frequency, valid, busy, no_signal, overrange
    );

    modport slave (
        input  rise_edge, freeze,
        output frequency, valid, busy, no_signal, overrange
    );
endinterface

// File: rtl/freq_measure_ctrl.sv
// Averages 2^AVG_LOG2 input periods, divides CLK_FREQ<<AVG_LOG2 by the count; valid 34 clocks after the final edge.
// No backpressure: freeze only gates the next start. FREQ_ROUND_EN selects round-to-nearest division.
module freq_measure_ctrl #(
    parameter int unsigned CLK_FREQ       = 50_000_000,
    parameter int unsigned AVG_LOG2       = 2,
    parameter int unsigned BIT_SIZE       = 20,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input  logic          clk,
    input  logic          rst,
    freq_measure_if.slave meas
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FIRST,
        S_MEASURE,
        S_DIVIDE,
        S_UPDATE
    } state_t;

    localparam int unsigned   EW           = AVG_LOG2 + 1;
    localparam logic [EW-1:0] EDGE_LAST    = EW'((1 << AVG_LOG2) - 1);
    localparam logic [31:0]   DIVIDEND     = 32'(CLK_FREQ << AVG_LOG2);
    localparam logic [31:0]   TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   FREQ_MAX     = 32'((64'd1 << BIT_SIZE) - 64'd1);

    state_t              state_q, state_d;
    logic [31:0]         timeout_q, timeout_d;
    logic [31:0]         sum_q, sum_d;
    logic [EW-1:0]       edges_q, edges_d;
    logic [31:0]         divisor_q, divisor_d;
    logic [31:0]         dq_q, dq_d;
    logic [31:0]         rem_q, rem_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic                timed_out_q, timed_out_d;
    logic [BIT_SIZE-1:0] freq_q, freq_d;
    logic                valid_q, valid_d;
    logic                no_signal_q, no_signal_d;
    logic                overrange_q, overrange_d;

    logic [32:0] trial;
    logic [32:0] diff;
    logic [31:0] load_dividend;
    logic        timeout_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            timeout_q   <= '0;
            sum_q       <= '0;
            edges_q     <= '0;
            divisor_q   <= '0;
            dq_q        <= '0;
            rem_q       <= '0;
            bit_cnt_q   <= '0;
            timed_out_q <= 1'b0;
            freq_q      <= '0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b0;
            overrange_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timeout_q   <= timeout_d;
            sum_q       <= sum_d;
            edges_q     <= edges_d;
            divisor_q   <= divisor_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            bit_cnt_q   <= bit_cnt_d;
            timed_out_q <= timed_out_d;
            freq_q      <= freq_d;
            valid_q     <= valid_d;
            no_signal_q <= no_signal_d;
            overrange_q <= overrange_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_d   = timeout_q;
        sum_d       = sum_q;
        edges_d     = edges_q;
        divisor_d   = divisor_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        bit_cnt_d   = bit_cnt_q;
        timed_out_d = timed_out_q;
        freq_d      = freq_q;
        valid_d     = 1'b0;
        no_signal_d = no_signal_q;
        overrange_d = overrange_q;

        // dq_q shifts dividend bits out of the top while quotient bits enter at the bottom
        trial = {rem_q, dq_q[31]};
        diff  = trial - {1'b0, divisor_q};
`ifdef FREQ_ROUND_EN
        load_dividend = DIVIDEND + ((sum_q + 32'd1) >> 1);
`else
        load_dividend = DIVIDEND;
`endif
        timeout_hit = (timeout_q == TIMEOUT_LAST);

        case (state_q)
            S_IDLE: begin
                if (!meas.freeze) begin
                    state_d     = S_WAIT_FIRST;
                    timeout_d   = '0;
                    sum_d       = '0;
                    edges_d     = '0;
                    timed_out_d = 1'b0;
                end
            end
            S_WAIT_FIRST: begin
                timeout_d = timeout_q + 32'd1;
                if (timeout_hit) begin
                    state_d     = S_UPDATE;
                    timed_out_d = 1'b1;
                end else if (meas.rise_edge) begin
                    state_d = S_MEASURE;
                    sum_d   = '0;
                    edges_d = '0;
                end
            end
            S_MEASURE: begin
                timeout_d = timeout_q + 32'd1;
                sum_d     = sum_q + 32'd1;
                if (timeout_hit) begin
                    state_d     = S_UPDATE;
                    timed_out_d = 1'b1;
                end else if (meas.rise_edge) begin
                    if (edges_q == EDGE_LAST) begin
                        // count includes the closing edge's cycle, so it equals 2^AVG_LOG2 periods
                        divisor_d = sum_q + 32'd1;
                        dq_d      = load_dividend;
                        rem_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = S_DIVIDE;
                    end else begin
                        edges_d = edges_q + EW'(1);
                    end
                end
            end
            S_DIVIDE: begin
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    dq_d  = {dq_q[30:0], 1'b1};
                end else begin
                    rem_d = trial[31:0];
                    dq_d  = {dq_q[30:0], 1'b0};
                end
                bit_cnt_d = bit_cnt_q + 5'd1;
                if (bit_cnt_q == 5'd31) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
                if (timed_out_q) begin
                    freq_d      = '0;
                    no_signal_d = 1'b1;
                    overrange_d = 1'b0;
                end else if (dq_q > FREQ_MAX) begin
                    freq_d      = '1;
                    no_signal_d = 1'b0;
                    overrange_d = 1'b1;
                end else begin
                    freq_d      = dq_q[BIT_SIZE-1:0];
                    no_signal_d = 1'b0;
                    overrange_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign meas.frequency = freq_q;
    assign meas.valid     = valid_q;
    assign meas.busy      = (state_q != S_IDLE);
    assign meas.no_signal = no_signal_q;
    assign meas.overrange = overrange_q;
endmodule

// File: tb/tb_freq_measure_ctrl.sv
// Directed bench: unit A (50 MHz, 1000-cycle timeout) and unit B (1 MHz clock scale for long periods).
module tb_freq_measure_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    freq_measure_if #(.BIT_SIZE(20)) ifa ();
    freq_measure_if #(.BIT_SIZE(20)) ifb ();

    freq_measure_ctrl #(
        .CLK_FREQ(50_000_000), .AVG_LOG2(2), .BIT_SIZE(20), .TIMEOUT_CYCLES(1000)
    ) dut_a (
        .clk(clk), .rst(rst), .meas(ifa)
    );

    freq_measure_ctrl #(
        .CLK_FREQ(1_000_000), .AVG_LOG2(2), .BIT_SIZE(20), .TIMEOUT_CYCLES(1_000_000)
    ) dut_b (
        .clk(clk), .rst(rst), .meas(ifb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_edge(input bit sel, input logic v);
        if (sel) ifb.rise_edge = v;
        else     ifa.rise_edge = v;
    endtask

    // Five edges spaced 'period' apart, then cycles from the final edge (inclusive) to valid.
    task automatic run_meas(input bit sel, input int period, input int freeze_after,
                            output int lat, output logic [19:0] f,
                            output logic ovr, output logic nos, output logic bsy);
        int  n;
        bit  seen;
        lat  = -1;
        seen = 1'b0;
        tick();
        tick();
        for (int e = 0; e < 5; e++) begin
            drive_edge(sel, 1'b1);
            tick();
            drive_edge(sel, 1'b0);
            if (!sel && e == freeze_after) ifa.freeze = 1'b1;
            if (e < 4) repeat (period - 1) tick();
        end
        n = 1;
        for (int i = 0; i < 60 && !seen; i++) begin
            tick();
            n++;
            if ((sel ? ifb.valid : ifa.valid) === 1'b1) begin
                lat  = n;
                seen = 1'b1;
            end
        end
        f   = sel ? ifb.frequency : ifa.frequency;
        ovr = sel ? ifb.overrange : ifa.overrange;
        nos = sel ? ifb.no_signal : ifa.no_signal;
        bsy = sel ? ifb.busy      : ifa.busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.rise_edge = 1'b0; ifa.freeze = 1'b0;
        ifb.rise_edge = 1'b0; ifb.freeze = 1'b0;
        repeat (3) tick();
        checks++; if (ifa.frequency !== 20'd0) begin errors++; $display("FAIL reset_freq got %0d want 0", ifa.frequency); end
        checks++; if (ifa.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifa.valid); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ifa.busy); end
        checks++; if (ifa.no_signal !== 1'b0) begin errors++; $display("FAIL reset_no_signal got %b want 0", ifa.no_signal); end
        checks++; if (ifa.overrange !== 1'b0) begin errors++; $display("FAIL reset_overrange got %b want 0", ifa.overrange); end
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int lat;
        logic [19:0] f;
        logic ovr, nos, bsy;
        n = -1;
        for (int i = 1; i <= 1100 && n < 0; i++) begin
            tick();
            if (ifa.valid === 1'b1) n = i;
        end
        // leave IDLE at clock 1, timeout counter hits 999 at clock 1001, UPDATE registers at 1002
        checks++; if (n !== 1002) begin errors++; $display("FAIL timeout_latency got %0d want 1002", n); end
        checks++; if (ifa.frequency !== 20'd0) begin errors++; $display("FAIL timeout_freq got %0d want 0", ifa.frequency); end
        checks++; if (ifa.no_signal !== 1'b1) begin errors++; $display("FAIL timeout_no_signal got %b want 1", ifa.no_signal); end
        checks++; if (ifa.overrange !== 1'b0) begin errors++; $display("FAIL timeout_overrange got %b want 0", ifa.overrange); end
        run_meas(1'b0, 100, -1, lat, f, ovr, nos, bsy);
        checks++; if (f !== 20'd500_000) begin errors++; $display("FAIL recover_freq got %0d want 500000", f); end
        checks++; if (nos !== 1'b0) begin errors++; $display("FAIL recover_no_signal got %b want 0", nos); end
    endtask

    task automatic test_basic();
        int lat;
        logic [19:0] f;
        logic ovr, nos, bsy;
        run_meas(1'b0, 50, -1, lat, f, ovr, nos, bsy);
        checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency got %0d want 34", lat); end
        checks++; if (f !== 20'd1_000_000) begin errors++; $display("FAIL basic_freq got %0d want 1000000", f); end
        checks++; if (nos !== 1'b0) begin errors++; $display("FAIL basic_no_signal got %b want 0", nos); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL basic_overrange got %b want 0", ovr); end
        checks++; if (bsy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b want 0", bsy); end
        tick();
        checks++; if (ifa.valid !== 1'b0) begin errors++; $display("FAIL basic_valid_pulse got %b want 0", ifa.valid); end
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL basic_restart_busy got %b want 1", ifa.busy); end
    endtask

    task automatic test_overrange();
        int lat;
        logic [19:0] f;
        logic ovr, nos, bsy;
        run_meas(1'b0, 7, -1, lat, f, ovr, nos, bsy);
        checks++; if (f !== 20'd1_048_575) begin errors++; $display("FAIL ovr_freq got %0d want 1048575", f); end
        checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", ovr); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL ovr_latency got %0d want 34", lat); end
        run_meas(1'b0, 100, -1, lat, f, ovr, nos, bsy);
        checks++; if (f !== 20'd500_000) begin errors++; $display("FAIL ovr_clear_freq got %0d want 500000", f); end
        checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear_flag got %b want 0", ovr); end
    endtask

    task automatic test_rate_change();
        int lat;
        logic [19:0] f;
        logic ovr, nos, bsy;
        // 4 MHz*cycle dividend on unit B: period 1000 -> 1000 Hz, period 500 -> 2000 Hz
        run_meas(1'b1, 1000, -1, lat, f, ovr, nos, bsy);
        checks++; if (f !== 20'd1000) begin errors++; $display("FAIL rate_1000 got %0d want 1000", f); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL rate_latency got %0d want 34", lat); end
        run_meas(1'b1, 500, -1, lat, f, ovr, nos, bsy);
        checks++; if (f !== 20'd2000) begin errors++; $display("FAIL rate_2000 got %0d want 2000", f); end
    endtask

    task automatic test_rounding();
        int lat;
        logic [19:0] f;
        logic ovr, nos, bsy;
        logic [19:0] want;
`ifdef FREQ_ROUND_EN
        want = 20'd1667;
`else
        want = 20'd1666;
`endif
        run_meas(1'b1, 600, -1, lat, f, ovr, nos, bsy);
        checks++; if (f !== want) begin errors++; $display("FAIL round_freq got %0d want %0d", f, want); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL round_latency got %0d want 34", lat); end
    endtask

    task automatic test_reset_divide();
        bit saw_valid;
        tick();
        tick();
        for (int e = 0; e < 5; e++) begin
            ifa.rise_edge = 1'b1;
            tick();
            ifa.rise_edge = 1'b0;
            if (e < 4) repeat (49) tick();
        end
        repeat (10) tick();
        checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL rstdiv_busy_before got %b want 1", ifa.busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ifa.frequency !== 20'd0) begin errors++; $display("FAIL rstdiv_freq got %0d want 0", ifa.frequency); end
        checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rstdiv_busy got %b want 0", ifa.busy); end
        checks++; if (ifa.valid !== 1'b0) begin errors++; $display("FAIL rstdiv_valid got %b want 0", ifa.valid); end
        tick();
        tick();
        rst = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ifa.valid === 1'b1) saw_valid = 1'b1;
        end
        checks++; if (saw_valid !== 1'b0) begin errors++; $display("FAIL rstdiv_no_valid got %b want 0", saw_valid); end
    endtask

    task automatic test_freeze();
        int lat;
        logic [19:0] f;
        logic ovr, nos, bsy;
        run_meas(1'b0, 50, 1, lat, f, ovr, nos, bsy);
        checks++; if (lat !== 34) begin errors++; $display("FAIL freeze_mid_latency got %0d want 34", lat); end
        checks++; if (f !== 20'd1_000_000) begin errors++; $display("FAIL freeze_mid_freq got %0d want 1000000", f); end
        for (int e = 0; e < 5; e++) begin
            ifa.rise_edge = 1'b1;
            tick();
            ifa.rise_edge = 1'b0;
            checks++;
            if ({ifa.valid, ifa.busy, ifa.frequency} !== {1'b0, 1'b0, 20'd1_000_000}) begin
                errors++;
                $display("FAIL freeze_hold got valid=%b busy=%b freq=%0d want 0 0 1000000", ifa.valid, ifa.busy, ifa.frequency);
            end
            repeat (6) tick();
        end
        repeat (40) tick();
        checks++; if ({ifa.valid, ifa.busy, ifa.frequency} !== {1'b0, 1'b0, 20'd1_000_000}) begin
            errors++;
            $display("FAIL freeze_final got valid=%b busy=%b freq=%0d want 0 0 1000000", ifa.valid, ifa.busy, ifa.frequency);
        end
        ifa.freeze = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired: checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_timeout();
        test_basic();
        test_overrange();
        test_rate_change();
        test_rounding();
        test_reset_divide();
        test_freeze();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
